msu: RTL and testbench
======================

# msu

Modular squaring unit for the VDF evaluation path. It receives a Montgomery-form value and a start/end iteration count over an AXI4-Stream slave. It then performs (END_CNT − START_CNT) Montgomery squarings modulo MODULUS and returns the result over an AXI4-Stream master. Host sequencing uses ap_start/ap_done, and start_xfer tells the host to begin sending input.

## Interface
- AXI_LEN, 32: stream data width in bits; multiple of 8.
- T_LEN, 64: iteration counter width.
- DAT_BITS, 128: operand width.
- MODULUS, 2^127−1: odd modulus, < 2^(DAT_BITS−1); R = 2^DAT_BITS.
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- s_axis_tvalid / s_axis_tready  in / out  1  input handshake.
- s_axis_tdata  in  AXI_LEN  input payload, little-endian beats.
- s_axis_tkeep  in  AXI_LEN/8  ignored.
- s_axis_tlast  in  1  final input beat.
- s_axis_xfer_size_in_bytes  out  32  constant IN_BYTES = (DAT_BITS+2·T_LEN+7)/8.
- m_axis_tvalid / m_axis_tready  out / in  1  output handshake.
- m_axis_tdata  out  AXI_LEN  result payload.
- m_axis_tkeep  out  AXI_LEN/8  byte enables.
- m_axis_tlast  out  1  final output beat.
- m_axis_xfer_size_in_bytes  out  32  constant OUT_BYTES = (DAT_BITS+7)/8.
- ap_start  in  1  start pulse.
- ap_done  out  1  one-cycle completion pulse.
- start_xfer  out  1  one-cycle "send input now" pulse.

## Operation
**States: IDLE → RECV → CALC → SEND → IDLE.**

**IDLE**
- ap_start=1 moves the unit to RECV.
- start_xfer pulses in the following cycle.
- ap_start outside IDLE is ignored.

**RECV**
- s_axis_tready=1 only in this state.
- Beat k fills shift-register bits [k·AXI_LEN +: AXI_LEN]. The register is cleared on entry.
- Packed field layout, LSB first: START_CNT [T_LEN−1:0], END_CNT [2T_LEN−1:T_LEN], value [2T_LEN+DAT_BITS−1:2T_LEN].
- Beats past ceil(IN_BYTES·8/AXI_LEN) are accepted and discarded.
- Reception ends on the beat carrying tlast. If tlast comes early, unfilled bits stay 0.

**CALC**
- cnt=START_CNT, acc=value.
- While cnt < END_CNT (unsigned): acc = MontMul(acc, acc) = acc²·R⁻¹ mod MODULUS, then cnt++.
- If START_CNT ≥ END_CNT, zero squarings are done and acc passes through unchanged.

**MontMul: radix-2, bit-serial, DAT_BITS+2-bit accumulator S**
- S=0.
- For i = 0 to DAT_BITS−1: S += a_i·b; if S is odd, S += MODULUS; S >>= 1.
- Final step: if S ≥ MODULUS, S −= MODULUS.
- Output is fully reduced.
- Input value is assumed < MODULUS; no checking.

**SEND**
- OUT_BEATS = ceil(DAT_BITS/AXI_LEN) beats, little-endian (beat 0 = acc[AXI_LEN−1:0]).
- m_axis_tkeep is all ones, except on the last beat, which enables only bytes < OUT_BYTES mod (AXI_LEN/8) when that value is nonzero.
- tlast is asserted on the last beat only.
- After the last beat is accepted: ap_done pulses for one cycle and the unit returns to IDLE.

## Timing
**Reset (asynchronous, active-low)**
- Forces IDLE.
- Outputs: tready=0, tvalid=0, tlast=0, tdata=0, tkeep=0, ap_done=0, start_xfer=0; accumulator and counters cleared.
- Reset mid-operation aborts with no output.

**Latency**
- ap_start sampled at edge t: start_xfer is high during cycle t+1, and s_axis_tready is high from t+1.
- After the tlast beat: CALC starts next cycle. Each squaring takes DAT_BITS+2 cycles (DAT_BITS iterations, 1 subtract, 1 bookkeeping).
- SEND asserts tvalid the cycle after CALC ends.

**Output handshake**
- tvalid, tdata, tkeep and tlast are held stable until tready.
- Beats advance only on tvalid & tready; there are no bubbles when tready stays high.
- ap_done is asserted in the cycle after the final handshake.

**Input handshake:** s_axis_tvalid with tready low has no effect.

## Test plan
Parameters for all scenarios: AXI_LEN=32, T_LEN=64, DAT_BITS=128, MODULUS=2^127−1.

1. **Main run:** ap_start pulse, then 8 beats {value=4 (Mont(2)), END=10, START=0}, tlast on beat 7 → start_xfer pulses once; output 4 beats 0x00000200, 0, 0, 0 (Mont(2^1024 mod N)=512), tkeep=0xF, tlast on beat 3, then one ap_done pulse.
2. **Single squaring:** START=0, END=1, value=4 → output 0x8.
3. **Zero squarings:** START=END=5, value=4 → output 0x4; START=7, END=3 → output 0x4.
4. **Backpressure:** scenario 1 with m_axis_tready toggling every cycle and s_axis_tvalid gapped → identical data; each beat held stable while tready is low.
5. **Reset mid-CALC:** reset low during CALC → all outputs 0, no output beats; a following normal run gives the correct result.
6. **Ignored ap_start:** ap_start pulse during CALC → no extra start_xfer, a single result packet, one ap_done.

Source files
------------

// File: rtl/msu_if.sv
// Stream and host-control bundle between the VDF host and the squaring unit.
// The slave modport is the unit's view and the master modport is the host's view.
interface msu_if #(parameter int AXI_LEN = 32);
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic [AXI_LEN-1:0]   s_axis_tdata;
  logic [AXI_LEN/8-1:0] s_axis_tkeep;
  logic                 s_axis_tlast;
  logic [31:0]          s_axis_xfer_size_in_bytes;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic [AXI_LEN-1:0]   m_axis_tdata;
  logic [AXI_LEN/8-1:0] m_axis_tkeep;
  logic                 m_axis_tlast;
  logic [31:0]          m_axis_xfer_size_in_bytes;
  logic                 ap_start;
  logic                 ap_done;
  logic                 start_xfer;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready, ap_start,
    output s_axis_tready, s_axis_xfer_size_in_bytes, m_axis_tvalid, m_axis_tdata,
           m_axis_tkeep, m_axis_tlast, m_axis_xfer_size_in_bytes, ap_done, start_xfer
  );
  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready, ap_start,
    input  s_axis_tready, s_axis_xfer_size_in_bytes, m_axis_tvalid, m_axis_tdata,
           m_axis_tkeep, m_axis_tlast, m_axis_xfer_size_in_bytes, ap_done, start_xfer
  );
endinterface

// File: rtl/msu.sv
// Modular squaring unit: receives {value, END_CNT, START_CNT}, applies (END-START)
// bit-serial radix-2 Montgomery squarings and streams the reduced result back.
module msu #(
  parameter int AXI_LEN  = 32,
  parameter int T_LEN    = 64,
  parameter int DAT_BITS = 128,
  parameter logic [DAT_BITS-1:0] MODULUS = {1'b0, {(DAT_BITS-1){1'b1}}}
) (
  input logic clk,
  input logic reset,
  msu_if.slave bus
);
  localparam int IN_BYTES  = (DAT_BITS + 2*T_LEN + 7) / 8;
  localparam int IN_BEATS  = (IN_BYTES*8 + AXI_LEN - 1) / AXI_LEN;
  localparam int IN_W      = IN_BEATS * AXI_LEN;
  localparam int OUT_BYTES = (DAT_BITS + 7) / 8;
  localparam int OUT_BEATS = (DAT_BITS + AXI_LEN - 1) / AXI_LEN;
  localparam int OUT_W     = OUT_BEATS * AXI_LEN;
  localparam int KW        = AXI_LEN / 8;
  localparam int KREM      = OUT_BYTES % KW;
  localparam logic [KW-1:0] KEEP_LAST = (KREM == 0) ? {KW{1'b1}} : KW'((1 << KREM) - 1);
  localparam int IBW = $clog2(IN_BEATS + 1) + 1;
  localparam int OBW = $clog2(OUT_BEATS) + 1;
  localparam int BW  = $clog2(DAT_BITS + 2);
  localparam int SW  = DAT_BITS + 2;

  typedef enum logic [1:0] {IDLE, RECV, CALC, SEND} st_t;

  st_t                st_q;
  logic [IBW-1:0]     ib_q;
  logic [IN_W-1:0]    sh_q;
  logic [T_LEN-1:0]   cnt_q, end_q;
  logic [DAT_BITS-1:0] acc_q;
  logic [SW-1:0]      s_q;
  logic [BW-1:0]      bi_q;
  logic [OBW-1:0]     ob_q;
  logic               tvalid_q, tlast_q, done_q, sx_q;
  logic [AXI_LEN-1:0] tdata_q;
  logic [KW-1:0]      tkeep_q;

  logic [IN_W-1:0]    sh_nxt;
  logic [SW-1:0]      add_b, t1, t2, s_it, s_red;
  logic [OUT_W-1:0]   obuf;
  logic [OBW-1:0]     nb;
  logic [AXI_LEN-1:0] beat_d;
  logic               unused_ok;

  assign bus.s_axis_tready             = (st_q == RECV);
  assign bus.s_axis_xfer_size_in_bytes = 32'(IN_BYTES);
  assign bus.m_axis_xfer_size_in_bytes = 32'(OUT_BYTES);
  assign bus.m_axis_tvalid             = tvalid_q;
  assign bus.m_axis_tdata              = tdata_q;
  assign bus.m_axis_tkeep              = tkeep_q;
  assign bus.m_axis_tlast              = tlast_q;
  assign bus.ap_done                   = done_q;
  assign bus.start_xfer                = sx_q;
  assign unused_ok                     = ^bus.s_axis_tkeep;
  assign obuf                          = OUT_W'(acc_q);

  // Beats beyond the packed frame are swallowed without touching the register.
  always_comb begin
    sh_nxt = sh_q;
    if (ib_q < IBW'(IN_BEATS)) sh_nxt[ib_q*AXI_LEN +: AXI_LEN] = bus.s_axis_tdata;
  end

  // One Montgomery step: S = (S + a_i*b [+ N]) / 2, with a = b = acc.
  always_comb begin
    add_b = acc_q[bi_q[$clog2(DAT_BITS)-1:0]] ? {2'b00, acc_q} : '0;
    t1    = s_q + add_b;
    t2    = t1[0] ? t1 + {2'b00, MODULUS} : t1;
    s_it  = t2 >> 1;
    s_red = (s_q >= {2'b00, MODULUS}) ? s_q - {2'b00, MODULUS} : s_q;
  end

  always_comb begin
    nb     = ob_q + 1'b1;
    beat_d = '0;
    if (nb < OBW'(OUT_BEATS)) beat_d = obuf[nb*AXI_LEN +: AXI_LEN];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= IDLE; ib_q <= '0; sh_q <= '0; cnt_q <= '0; end_q <= '0; acc_q <= '0;
      s_q <= '0; bi_q <= '0; ob_q <= '0; tvalid_q <= 1'b0; tlast_q <= 1'b0;
      done_q <= 1'b0; sx_q <= 1'b0; tdata_q <= '0; tkeep_q <= '0;
    end else begin
      sx_q   <= 1'b0;
      done_q <= 1'b0;
      case (st_q)
        IDLE: if (bus.ap_start) begin
          st_q <= RECV; sx_q <= 1'b1; sh_q <= '0; ib_q <= '0;
        end
        RECV: if (bus.s_axis_tvalid) begin
          sh_q <= sh_nxt;
          if (ib_q < IBW'(IN_BEATS)) ib_q <= ib_q + 1'b1;
          if (bus.s_axis_tlast) begin
            st_q  <= CALC;
            cnt_q <= sh_nxt[T_LEN-1:0];
            end_q <= sh_nxt[2*T_LEN-1:T_LEN];
            acc_q <= sh_nxt[2*T_LEN +: DAT_BITS];
            s_q   <= '0;
            bi_q  <= '0;
          end
        end
        // Each squaring: DAT_BITS steps, one reduction, one bookkeeping cycle.
        CALC: begin
          if (bi_q == '0 && cnt_q >= end_q) begin
            st_q     <= SEND;
            ob_q     <= '0;
            tvalid_q <= 1'b1;
            tdata_q  <= obuf[AXI_LEN-1:0];
            tkeep_q  <= (OUT_BEATS == 1) ? KEEP_LAST : {KW{1'b1}};
            tlast_q  <= (OUT_BEATS == 1);
          end else if (bi_q < BW'(DAT_BITS)) begin
            s_q  <= s_it;
            bi_q <= bi_q + 1'b1;
          end else if (bi_q == BW'(DAT_BITS)) begin
            s_q  <= s_red;
            bi_q <= bi_q + 1'b1;
          end else begin
            acc_q <= s_q[DAT_BITS-1:0];
            cnt_q <= cnt_q + 1'b1;
            s_q   <= '0;
            bi_q  <= '0;
          end
        end
        SEND: if (bus.m_axis_tready) begin
          if (tlast_q) begin
            tvalid_q <= 1'b0; tlast_q <= 1'b0; tkeep_q <= '0; tdata_q <= '0;
            done_q   <= 1'b1;
            st_q     <= IDLE;
          end else begin
            ob_q    <= nb;
            tdata_q <= beat_d;
            tlast_q <= (nb == OBW'(OUT_BEATS - 1));
            tkeep_q <= (nb == OBW'(OUT_BEATS - 1)) ? KEEP_LAST : {KW{1'b1}};
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_msu.sv
// Bench for msu: directed scenarios plus random runs against an arithmetic
// model computing acc^2 * R^-1 mod N with wide integer math.
module tb_msu;
  localparam logic [127:0] N = {1'b0, {127{1'b1}}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  msu_if #(.AXI_LEN(32)) bus();
  msu #(.AXI_LEN(32), .T_LEN(64), .DAT_BITS(128)) dut (.clk(clk), .reset(rst_n), .bus(bus));

  int vectors = 0, miscompares = 0;
  int done_cnt = 0, sx_cnt = 0, tv_cnt = 0;
  logic [127:0] rinv;

  always @(posedge clk) begin
    if (bus.ap_done)       done_cnt <= done_cnt + 1;
    if (bus.start_xfer)    sx_cnt   <= sx_cnt + 1;
    if (bus.m_axis_tvalid) tv_cnt   <= tv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mont_sq(input logic [127:0] a);
    logic [255:0] p;
    p = ({128'd0, a} * {128'd0, a}) % {128'd0, N};
    p = (p * {128'd0, rinv}) % {128'd0, N};
    return p[127:0];
  endfunction

  function automatic logic [127:0] ref_run(input logic [127:0] v, input logic [63:0] s, input logic [63:0] e);
    logic [127:0] acc = v;
    if (s < e) for (longint unsigned c = 0; c < e - s; c++) acc = mont_sq(acc);
    return acc;
  endfunction

  function automatic logic [127:0] rnd_val();
    logic [127:0] v = {$urandom, $urandom, $urandom, $urandom} & N;
    if (v == N) v = v - 1;
    return v;
  endfunction

  task automatic do_start(input bit expect_sx);
    @(negedge clk) bus.ap_start = 1'b1;
    @(negedge clk) bus.ap_start = 1'b0;
    chk("start_xfer_pulse", {127'd0, bus.start_xfer}, {127'd0, expect_sx});
    chk("s_tready_after_start", {127'd0, bus.s_axis_tready}, {127'd0, expect_sx});
    @(negedge clk);
    chk("start_xfer_low", {127'd0, bus.start_xfer}, 128'd0);
  endtask

  task automatic send_in(input logic [127:0] v, input logic [63:0] s, input logic [63:0] e,
                         input int nbeats, input bit gap);
    logic [255:0] pk = {v, e, s};
    for (int k = 0; k < nbeats; k++) begin
      int w = 0;
      @(negedge clk);
      if (gap && $urandom_range(0, 1) == 1) begin
        bus.s_axis_tvalid = 1'b0;
        @(negedge clk);
      end
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = (k < 8) ? pk[k*32 +: 32] : $urandom;
      bus.s_axis_tkeep  = 4'(k);
      bus.s_axis_tlast  = (k == nbeats - 1);
      while (!bus.s_axis_tready && w < 100) begin @(negedge clk); w++; end
      if (w >= 100) begin chk("s_tready_timeout", 128'd1, 128'd0); break; end
      @(posedge clk);
    end
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  // mode 0: always ready, 1: toggling ready, 2: random ready
  task automatic recv_out(output logic [127:0] d, input int mode);
    int beats = 0, w = 0, wfirst = 0, wlast = 0;
    bit held = 1'b0, rdy;
    logic [31:0] hd; logic [3:0] hk; logic hl;
    d = '0;
    while (beats < 4 && w < 20000) begin
      @(negedge clk); w++;
      if (held) begin
        chk("hold_valid", {127'd0, bus.m_axis_tvalid}, 128'd1);
        chk("hold_data", {96'd0, bus.m_axis_tdata}, {96'd0, hd});
        chk("hold_keep_last", {123'd0, bus.m_axis_tkeep, bus.m_axis_tlast}, {123'd0, hk, hl});
        held = 1'b0;
      end
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? w[0] : 1'($urandom_range(0, 1));
      bus.m_axis_tready = rdy;
      if (bus.m_axis_tvalid) begin
        if (rdy) begin
          if (beats == 0) wfirst = w;
          wlast = w;
          d[beats*32 +: 32] = bus.m_axis_tdata;
          chk("m_tkeep", {124'd0, bus.m_axis_tkeep}, 128'hF);
          chk("m_tlast", {127'd0, bus.m_axis_tlast}, {127'd0, beats == 3});
          beats++;
        end else begin
          held = 1'b1; hd = bus.m_axis_tdata; hk = bus.m_axis_tkeep; hl = bus.m_axis_tlast;
        end
      end
    end
    if (beats < 4) begin
      chk("m_tvalid_timeout", 128'd1, 128'd0);
    end else begin
      if (mode == 0) chk("no_bubbles", 128'(wlast - wfirst), 128'd3);
      @(negedge clk);
      bus.m_axis_tready = 1'b0;
      chk("ap_done_pulse", {127'd0, bus.ap_done}, 128'd1);
      chk("tvalid_drop", {127'd0, bus.m_axis_tvalid}, 128'd0);
      @(negedge clk);
      chk("ap_done_low", {127'd0, bus.ap_done}, 128'd0);
    end
  endtask

  task automatic run(input string tag, input logic [127:0] v, input logic [63:0] s,
                     input logic [63:0] e, input int nbeats, input int mode, input bit gap,
                     input logic [127:0] exp);
    logic [127:0] d;
    do_start(1'b1);
    send_in(v, s, e, nbeats, gap);
    recv_out(d, mode);
    chk(tag, d, exp);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk(tag, {bus.s_axis_tready, bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata,
              bus.m_axis_tkeep, bus.ap_done, bus.start_xfer}, 128'd0);
  endtask

  initial begin
    logic [127:0] d, v;
    logic [63:0] s, e;
    int dc0, sx0, tv0;
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = '0; bus.s_axis_tkeep = '0;
    bus.s_axis_tlast = 1'b0; bus.m_axis_tready = 1'b0; bus.ap_start = 1'b0;
    rinv = 128'd1;
    for (int i = 0; i < 128; i++) rinv = 128'(({128'd0, rinv} * {128'd0, (N + 128'd1) >> 1}) % {128'd0, N});

    #22;
    chk_outs_zero("reset_outputs");
    chk("xfer_sizes", {64'd0, bus.s_axis_xfer_size_in_bytes, bus.m_axis_xfer_size_in_bytes},
        {64'd0, 32'd32, 32'd16});
    @(negedge clk) rst_n = 1'b1;

    // Main run, checked both against the model and the known result.
    chk("model_sanity", ref_run(128'd4, 64'd0, 64'd10), 128'd512);
    sx0 = sx_cnt; dc0 = done_cnt;
    run("main_run", 128'd4, 64'd0, 64'd10, 8, 0, 1'b0, 128'd512);
    chk("main_counts", {64'd0, 32'(sx_cnt - sx0), 32'(done_cnt - dc0)}, {64'd0, 32'd1, 32'd1});

    // Input valid while idle must be ignored.
    @(negedge clk) bus.s_axis_tvalid = 1'b1; bus.s_axis_tdata = 32'hDEADBEEF; bus.s_axis_tlast = 1'b1;
    repeat (3) @(negedge clk);
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
    run("single_square", 128'd4, 64'd0, 64'd1, 8, 0, 1'b0, 128'd8);
    run("zero_sq_equal", 128'd4, 64'd5, 64'd5, 8, 0, 1'b0, 128'd4);
    run("zero_sq_reverse", 128'd4, 64'd7, 64'd3, 8, 0, 1'b0, 128'd4);
    run("backpressure", 128'd4, 64'd0, 64'd10, 8, 1, 1'b1, 128'd512);

    // Reset during CALC aborts with no output.
    do_start(1'b1);
    send_in(128'd4, 64'd0, 64'd10, 8, 1'b0);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_outs_zero("reset_mid_calc");
    tv0 = tv_cnt;
    @(negedge clk) rst_n = 1'b1;
    repeat (1500) @(negedge clk);
    chk("no_output_after_abort", 128'(tv_cnt - tv0), 128'd0);
    run("after_reset", 128'd4, 64'd0, 64'd1, 8, 0, 1'b0, 128'd8);

    // ap_start during CALC is ignored.
    sx0 = sx_cnt; dc0 = done_cnt;
    do_start(1'b1);
    send_in(128'd4, 64'd0, 64'd3, 8, 1'b0);
    repeat (20) @(negedge clk);
    do_start(1'b0);
    recv_out(d, 2);
    chk("ignored_start_data", d, ref_run(128'd4, 64'd0, 64'd3));
    tv0 = tv_cnt;
    repeat (300) @(negedge clk);
    chk("ignored_start_counts", {32'd0, 32'(sx_cnt - sx0), 32'(done_cnt - dc0), 32'(tv_cnt - tv0)},
        {32'd0, 32'd1, 32'd1, 32'd0});

    // Early tlast: value top word never arrives and stays zero.
    v = rnd_val();
    run("early_tlast", v, 64'd0, 64'd2, 7, 0, 1'b0, ref_run(v & {32'd0, {96{1'b1}}}, 64'd0, 64'd2));
    // Extra beats past the frame are discarded.
    v = rnd_val();
    run("extra_beats", v, 64'd4, 64'd6, 11, 2, 1'b1, ref_run(v, 64'd4, 64'd6));

    for (int i = 0; i < 5; i++) begin
      v = rnd_val();
      s = {$urandom, $urandom};
      e = (i == 4) ? s - 64'd1 : s + 64'($urandom_range(0, 3));
      run("random_run", v, s, e, 8, 2, 1'($urandom_range(0, 1)), ref_run(v, s, e));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
